// File: rtl/controller_rx_array.sv
// Multi-channel serial game-controller receiver: per-channel synchronised
// shift-in of button frames, live state plus sticky newly-pressed bits.
module controller_rx_lane #(
  parameter int FRAME_BITS      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int IDLE_CYCLES     = 1000,
  parameter int ACTIVE_LOW_BTNS = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  det_en,
  input  logic                  data_raw,
  input  logic                  clk_raw,
  input  logic                  clr,
  output logic [FRAME_BITS-1:0] state,
  output logic                  valid,
  output logic                  frame_err,
  output logic [FRAME_BITS-1:0] sticky
);
  localparam int CW = $clog2(FRAME_BITS);
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] data_sync, clk_sync;
  logic                   clk_prev, done;
  logic [FRAME_BITS-1:0]  sreg;
  logic [CW-1:0]          bit_cnt;
  logic [IW-1:0]          idle_cnt;
  logic                   rise, bit_in, last_bit, timeout;

  always_comb begin
    rise     = det_en & clk_sync[SYNC_STAGES-1] & ~clk_prev;
    bit_in   = data_sync[SYNC_STAGES-1] ^ (ACTIVE_LOW_BTNS != 0);
    last_bit = (bit_cnt == CW'(FRAME_BITS - 1));
    timeout  = !rise && (idle_cnt == IW'(IDLE_CYCLES)) && (bit_cnt != '0);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      data_sync <= '0;
      clk_sync  <= '0;
      clk_prev  <= 1'b0;
      done      <= 1'b0;
      sreg      <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      state     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      sticky    <= '0;
    end else begin
      data_sync <= {data_sync[SYNC_STAGES-2:0], data_raw};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], clk_raw};
      // prev tracks the synced clock even while detection is masked
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      done      <= rise & last_bit;
      valid     <= done;
      frame_err <= timeout;
      if (rise) begin
        sreg     <= {sreg[FRAME_BITS-2:0], bit_in};
        idle_cnt <= '0;
        bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
      end else begin
        if (idle_cnt != IW'(IDLE_CYCLES)) idle_cnt <= idle_cnt + 1'b1;
        if (timeout) begin
          bit_cnt <= '0;
          sreg    <= '0;
        end
      end
      if (done) state <= sreg;
      // a completing frame's new presses survive a same-cycle clear
      sticky <= (clr ? '0 : sticky) | (done ? (sreg & ~state) : '0);
    end
  end
endmodule

module controller_rx_array #(
  parameter int NUM_CH          = 2,
  parameter int FRAME_BITS      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int IDLE_CYCLES     = 1000,
  parameter int ACTIVE_LOW_BTNS = 1,
  localparam int CHW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_CH-1:0]            chip_data_raw,
  input  logic [NUM_CH-1:0]            chip_clk_raw,
  output logic [NUM_CH*FRAME_BITS-1:0] state_out,
  output logic [NUM_CH-1:0]            valid_out,
  output logic [NUM_CH-1:0]            frame_err_out,
  input  logic                         rd_en_in,
  input  logic [CHW-1:0]               rd_ch_in,
  output logic [FRAME_BITS-1:0]        rd_data_out,
  output logic                         rd_valid_out
);
  typedef struct packed {
    logic           en;
    logic [CHW-1:0] ch;
  } rd_req_t;

  rd_req_t                               rd_req;
  logic [SYNC_STAGES:0]                  vld_pipe;
  logic [NUM_CH-1:0][FRAME_BITS-1:0]     state_arr, sticky_arr;
  logic [NUM_CH-1:0]                     clr;
  logic [FRAME_BITS-1:0]                 rd_sel;

  assign rd_req    = '{en: rd_en_in, ch: rd_ch_in};
  assign state_out = state_arr;

  // edge detection opens SYNC_STAGES+1 cycles after reset release
  always_ff @(posedge clk_in) begin
    if (!rst_in) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign clr[c] = rd_req.en && (rd_req.ch == CHW'(c));
    controller_rx_lane #(
      .FRAME_BITS(FRAME_BITS), .SYNC_STAGES(SYNC_STAGES),
      .IDLE_CYCLES(IDLE_CYCLES), .ACTIVE_LOW_BTNS(ACTIVE_LOW_BTNS)
    ) u_lane (
      .clk_in(clk_in), .rst_in(rst_in), .det_en(vld_pipe[SYNC_STAGES]),
      .data_raw(chip_data_raw[c]), .clk_raw(chip_clk_raw[c]), .clr(clr[c]),
      .state(state_arr[c]), .valid(valid_out[c]),
      .frame_err(frame_err_out[c]), .sticky(sticky_arr[c])
    );
  end

  // out-of-range channels match no lane and read as zero
  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (rd_req.ch == CHW'(c)) rd_sel = sticky_arr[c];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_data_out  <= '0;
      rd_valid_out <= 1'b0;
    end else begin
      rd_valid_out <= rd_req.en;
      if (rd_req.en) rd_data_out <= rd_sel;
    end
  end
endmodule

// File: tb/tb_controller_rx_array.sv
// Directed bench for controller_rx_array: framing, latency, sticky reads,
// idle timeout, reset mid-frame, multi-channel and out-of-range reads.
module tb_controller_rx_array;
  localparam int FB = 8, SS = 2, IDLE = 200, PH = 20;

  logic        clk_in = 1'b0, rst_in = 1'b0;
  logic [1:0]  chip_data_raw = '0, chip_clk_raw = '0;
  logic        rd_en_in = 1'b0, rd_ch_in = 1'b0;
  logic [15:0] state_out;
  logic [1:0]  valid_out, frame_err_out;
  logic [7:0]  rd_data_out;
  logic        rd_valid_out;

  logic        rd_en1 = 1'b0, rd_ch1 = 1'b0;
  logic [7:0]  state1, rd_data1;
  logic        valid1, ferr1, rd_valid1;

  controller_rx_array #(.NUM_CH(2), .FRAME_BITS(FB), .SYNC_STAGES(SS),
    .IDLE_CYCLES(IDLE), .ACTIVE_LOW_BTNS(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .chip_data_raw(chip_data_raw),
    .chip_clk_raw(chip_clk_raw), .state_out(state_out), .valid_out(valid_out),
    .frame_err_out(frame_err_out), .rd_en_in(rd_en_in), .rd_ch_in(rd_ch_in),
    .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out));

  // single-channel instance listening to channel 0's wires
  controller_rx_array #(.NUM_CH(1), .FRAME_BITS(FB), .SYNC_STAGES(SS),
    .IDLE_CYCLES(IDLE), .ACTIVE_LOW_BTNS(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .chip_data_raw(chip_data_raw[0]),
    .chip_clk_raw(chip_clk_raw[0]), .state_out(state1), .valid_out(valid1),
    .frame_err_out(ferr1), .rd_en_in(rd_en1), .rd_ch_in(rd_ch1),
    .rd_data_out(rd_data1), .rd_valid_out(rd_valid1));

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  int vcnt[2], ecnt[2], vcyc[2];
  always @(negedge clk_in)
    for (int c = 0; c < 2; c++) begin
      if (valid_out[c]) begin vcnt[c]++; vcyc[c] = cyc; end
      if (frame_err_out[c]) ecnt[c]++;
    end

  int n_chk = 0, n_err = 0, rise_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // MSB-first; returns at the negedge the last bit's raw clock rises
  task automatic send(input logic [1:0] m, input logic [7:0] r0, input logic [7:0] r1,
                      input int n);
    for (int k = 0; k < n; k++) begin
      chip_clk_raw = chip_clk_raw & ~m;
      if (m[0]) chip_data_raw[0] = r0[7-k];
      if (m[1]) chip_data_raw[1] = r1[7-k];
      repeat (PH) @(negedge clk_in);
      chip_clk_raw = chip_clk_raw | m;
      rise_cyc = cyc;
      if (k != n-1) repeat (PH) @(negedge clk_in);
    end
  endtask

  task automatic do_read(input logic ch, output logic [7:0] d, output logic v);
    rd_en_in = 1'b1; rd_ch_in = ch;
    @(negedge clk_in);
    rd_en_in = 1'b0;
    d = rd_data_out; v = rd_valid_out;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, {16'h0, state_out}, 32'h0);
    chk({tag, "_valid"}, {30'h0, valid_out}, 32'h0);
    chk({tag, "_ferr"}, {30'h0, frame_err_out}, 32'h0);
    chk({tag, "_rdata"}, {24'h0, rd_data_out}, 32'h0);
    chk({tag, "_rvalid"}, {31'h0, rd_valid_out}, 32'h0);
    chk({tag, "_dut1"}, {state1, rd_data1, 5'h0, valid1, ferr1, rd_valid1}, 32'h0);
  endtask

  initial begin
    logic [7:0] d;
    logic v;
    int v0, v1, e0, e1;

    repeat (3) @(negedge clk_in);
    chk_idle_outputs("reset");
    rst_in = 1'b1;
    repeat (5) @(negedge clk_in);

    // frame receive and latency
    v0 = vcnt[0];
    send(2'b01, 8'hFA, 8'h00, 8);
    repeat (3) @(negedge clk_in);
    chk("lat_early_valid", {31'h0, valid_out[0]}, 32'h0);
    chk("lat_early_state", {24'h0, state_out[7:0]}, 32'h0);
    @(negedge clk_in);
    chk("frame_valid", {31'h0, valid_out[0]}, 32'h1);
    chk("frame_state", {24'h0, state_out[7:0]}, 32'h05);
    repeat (PH) @(negedge clk_in);
    chk("frame_vcount", vcnt[0] - v0, 32'd1);
    chk("frame_latency", vcyc[0] - rise_cyc, SS + 2);
    chk("frame_ch1_quiet", {24'h0, state_out[15:8]}, 32'h0);

    // sticky pressed, clear on read
    send(2'b01, 8'hF3, 8'h00, 8);
    repeat (PH) @(negedge clk_in);
    chk("sticky_state", {24'h0, state_out[7:0]}, 32'h0C);
    do_read(1'b0, d, v);
    chk("sticky_rd1", {23'h0, v, d}, {23'h0, 1'b1, 8'h0D});
    do_read(1'b0, d, v);
    chk("sticky_rd2", {23'h0, v, d}, {23'h0, 1'b1, 8'h00});
    @(negedge clk_in);
    chk("rvalid_pulse", {31'h0, rd_valid_out}, 32'h0);

    // idle timeout on a 5-bit partial frame
    e0 = ecnt[0]; v0 = vcnt[0];
    send(2'b01, 8'h55, 8'h00, 5);
    repeat (IDLE + 20) @(negedge clk_in);
    chk("timeout_err", ecnt[0] - e0, 32'd1);
    chk("timeout_novalid", vcnt[0] - v0, 32'd0);
    chk("timeout_state", {24'h0, state_out[7:0]}, 32'h0C);
    send(2'b01, 8'h7E, 8'h00, 8);
    repeat (PH) @(negedge clk_in);
    chk("after_timeout_state", {24'h0, state_out[7:0]}, 32'h81);
    chk("after_timeout_vcount", vcnt[0] - v0, 32'd1);
    do_read(1'b0, d, v);
    chk("after_timeout_rd", {24'h0, d}, 32'h81);

    // set wins over clear on channel 1
    send(2'b10, 8'h00, 8'hFE, 8);
    repeat (PH) @(negedge clk_in);
    chk("ch1_state_a", {24'h0, state_out[15:8]}, 32'h01);
    send(2'b10, 8'h00, 8'hF6, 8);
    repeat (3) @(negedge clk_in);
    rd_en_in = 1'b1; rd_ch_in = 1'b1;
    @(negedge clk_in);
    rd_en_in = 1'b0;
    chk("setwin_same_cycle", {31'h0, valid_out[1]}, 32'h1);
    chk("setwin_rd", {23'h0, rd_valid_out, rd_data_out}, {23'h0, 1'b1, 8'h01});
    repeat (PH) @(negedge clk_in);
    do_read(1'b1, d, v);
    chk("setwin_rd2", {24'h0, d}, 32'h08);
    chk("ch1_state_b", {24'h0, state_out[15:8]}, 32'h09);

    // reset mid-frame with raw clock held high through release
    send(2'b01, 8'h00, 8'h00, 3);
    repeat (5) @(negedge clk_in);
    v0 = vcnt[0]; v1 = vcnt[1]; e0 = ecnt[0]; e1 = ecnt[1];
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk_idle_outputs("midreset");
    rst_in = 1'b1;
    repeat (30) @(negedge clk_in);
    chk("rst_no_pulse", {vcnt[0] - v0, vcnt[1] - v1, ecnt[0] - e0, ecnt[1] - e1}, 32'h0);
    chk("rst_state", {16'h0, state_out}, 32'h0);
    send(2'b01, 8'hA5, 8'h00, 8);
    repeat (PH) @(negedge clk_in);
    chk("rst_frame_state", {24'h0, state_out[7:0]}, 32'h5A);
    chk("rst_frame_vcount", vcnt[0] - v0, 32'd1);

    // simultaneous completion on both channels
    send(2'b11, 8'hC3, 8'hBD, 8);
    repeat (4) @(negedge clk_in);
    chk("both_valid", {30'h0, valid_out}, 32'h3);
    repeat (PH) @(negedge clk_in);
    chk("both_state", {16'h0, state_out}, 32'h423C);
    chk("both_same_cycle", vcyc[0] - vcyc[1], 32'd0);
    do_read(1'b0, d, v);
    chk("both_rd0", {24'h0, d}, 32'h7E);
    do_read(1'b1, d, v);
    chk("both_rd1", {24'h0, d}, 32'h42);

    // out-of-range read on the single-channel instance
    chk("dut1_state", {24'h0, state1}, 32'h3C);
    rd_en1 = 1'b1; rd_ch1 = 1'b1;
    @(negedge clk_in);
    rd_en1 = 1'b0;
    chk("oor_rd", {23'h0, rd_valid1, rd_data1}, {23'h0, 1'b1, 8'h00});
    rd_en1 = 1'b1; rd_ch1 = 1'b0;
    @(negedge clk_in);
    rd_en1 = 1'b0;
    chk("oor_untouched", {23'h0, rd_valid1, rd_data1}, {23'h0, 1'b1, 8'h7E});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
